conv55_seq_ctrl: RTL and testbench

- Sequencer in front of the 5x5 convolution datapath (25 multipliers plus adder tree, 6-bit operands, 18-bit sum).
- Loads the 25 kernel taps serially into a weight bank, then collects 25 pixels per window over a valid/ready stream.
- Presents both 150-bit packed buses to the datapath, waits a fixed settle latency, captures the 18-bit result and returns it on a valid/ready output.
- The kernel persists across windows, so one load serves many windows.

---
 rtl/conv55_seq_ctrl_if.sv | 32 +++
 rtl/conv55_seq_ctrl.sv | 111 +++++++++++
 tb/tb_conv55_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv55_seq_ctrl_if.sv
// Handshake and bus bundle between the 5x5 convolution sequencer and its neighbours:
// the kernel loader, the pixel stream, the datapath and the result sink.
interface conv55_seq_ctrl_if #(
  parameter int DATA_W = 6,
  parameter int TAPS   = 25,
  parameter int OUT_W  = 18
);
  logic                   k_load_start;
  logic                   k_wr_en;
  logic [DATA_W-1:0]      k_wr_data;
  logic                   k_loaded;
  logic                   px_valid;
  logic [DATA_W-1:0]      px_data;
  logic                   px_ready;
  logic [TAPS*DATA_W-1:0] conv_in_data;
  logic [TAPS*DATA_W-1:0] conv_kernel;
  logic [OUT_W-1:0]       conv_result;
  logic                   out_valid;
  logic [OUT_W-1:0]       out_data;
  logic                   out_ready;
  logic                   busy;

  modport master (
    output k_load_start, k_wr_en, k_wr_data, px_valid, px_data, conv_result, out_ready,
    input  k_loaded, px_ready, conv_in_data, conv_kernel, out_valid, out_data, busy
  );

  modport slave (
    input  k_load_start, k_wr_en, k_wr_data, px_valid, px_data, conv_result, out_ready,
    output k_loaded, px_ready, conv_in_data, conv_kernel, out_valid, out_data, busy
  );
endinterface

// File: rtl/conv55_seq_ctrl.sv
// Sequencer for the 5x5 convolution datapath: serial kernel load, 25-pixel window
// collection, fixed settle wait, then result hand-off over valid/ready.
module conv55_seq_ctrl #(
  parameter int DATA_W   = 6,
  parameter int TAPS     = 25,
  parameter int OUT_W    = 18,
  parameter int CONV_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  conv55_seq_ctrl_if.slave  bus
);
  localparam int IDX_W = $clog2(TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS-1);
  localparam logic [3:0]       LAT_END  = 4'(CONV_LAT);

  typedef enum logic [2:0] {IDLE, LOAD_K, LOAD_W, COMPUTE, OUT} state_t;

  state_t                        state, state_n;
  logic [IDX_W-1:0]              idx;
  logic [3:0]                    lat_cnt;
  logic [TAPS-1:0][DATA_W-1:0]   pix_q, ker_q;
  logic                          k_loaded;
  logic                          out_valid;
  logic [OUT_W-1:0]              out_data;
  logic                          px_rdy, px_hs, k_wr, at_last, cap;

  assign px_hs   = bus.px_valid & px_rdy;
  assign k_wr    = (state == LOAD_K) & bus.k_wr_en;
  assign at_last = (idx == LAST_IDX);
  // Capture lands CONV_LAT+1 edges after the edge that took the last pixel.
  assign cap     = (state == COMPUTE) && (lat_cnt == LAT_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    px_rdy  = 1'b0;
    case (state)
      IDLE: begin
        // A kernel-load request wins over a pixel offered in the same cycle.
        px_rdy = k_loaded & ~bus.k_load_start;
        if (bus.k_load_start)            state_n = LOAD_K;
        else if (bus.px_valid && px_rdy) state_n = LOAD_W;
      end
      LOAD_K:  if (k_wr && at_last)     state_n = IDLE;
      LOAD_W: begin
        px_rdy = 1'b1;
        if (bus.px_valid && at_last)    state_n = COMPUTE;
      end
      COMPUTE: if (cap)                 state_n = OUT;
      OUT:     if (bus.out_ready)       state_n = IDLE;
      default:                          state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      lat_cnt   <= '0;
      pix_q     <= '0;
      ker_q     <= '0;
      k_loaded  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.k_load_start) begin
            idx      <= '0;
            k_loaded <= 1'b0;
          end else if (px_hs) begin
            idx <= IDX_W'(1);
          end
        end
        LOAD_K: if (k_wr) begin
          idx <= at_last ? '0 : idx + IDX_W'(1);
          if (at_last) k_loaded <= 1'b1;
        end
        LOAD_W: if (px_hs) begin
          idx <= at_last ? '0 : idx + IDX_W'(1);
          if (at_last) lat_cnt <= '0;
        end
        COMPUTE: begin
          lat_cnt <= cap ? '0 : lat_cnt + 4'd1;
          if (cap) begin
            out_data  <= bus.conv_result;
            out_valid <= 1'b1;
          end
        end
        OUT: if (bus.out_ready) out_valid <= 1'b0;
        default: ;
      endcase
      for (int i = 0; i < TAPS; i++) begin
        if (px_hs && idx == IDX_W'(i)) pix_q[i] <= bus.px_data;
        if (k_wr  && idx == IDX_W'(i)) ker_q[i] <= bus.k_wr_data;
      end
    end
  end

  assign bus.px_ready     = px_rdy;
  assign bus.k_loaded     = k_loaded;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_data;
  assign bus.busy         = (state != IDLE);
  assign bus.conv_in_data = pix_q;
  assign bus.conv_kernel  = ker_q;
endmodule

// File: tb/tb_conv55_seq_ctrl.sv
// Scoreboard bench for conv55_seq_ctrl: an ideal dot-product datapath, a queue of
// expected results from a bench-side kernel/pixel model, and a decoupled output monitor.
module tb_conv55_seq_ctrl;
  localparam int DW   = 6;
  localparam int TAPS = 25;
  localparam int OW   = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv55_seq_ctrl_if #(.DATA_W(DW), .TAPS(TAPS), .OUT_W(OW)) ifc ();

  conv55_seq_ctrl #(.DATA_W(DW), .TAPS(TAPS), .OUT_W(OW), .CONV_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [TAPS-1:0][DW-1:0] ker_m, pix_m, new_ker;
  int exp_q[$];

  // Ideal datapath: unsigned dot product of whatever the controller presents.
  always_comb begin : datapath
    int acc;
    acc = 0;
    for (int i = 0; i < TAPS; i++)
      acc += int'(ifc.conv_in_data[DW*i +: DW]) * int'(ifc.conv_kernel[DW*i +: DW]);
    ifc.conv_result = acc[OW-1:0];
  end

  function automatic int dot(input logic [TAPS-1:0][DW-1:0] a, input logic [TAPS-1:0][DW-1:0] b);
    int s = 0;
    for (int i = 0; i < TAPS; i++) s += int'(a[i]) * int'(b[i]);
    return s;
  endfunction

  task automatic chk(input string nm, input logic [149:0] act, input logic [149:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  task automatic timeout(input string nm, input int got, input int want);
    n_total++;
    $display("FAIL %s: got %0d want %0d", nm, got, want);
  endtask

  // Monitor: pops on every output handshake and checks hold-while-stalled.
  initial begin : monitor
    logic pv, phs;
    logic [OW-1:0] pd;
    int e;
    pv = 1'b0; phs = 1'b0; pd = '0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        pv = 1'b0; phs = 1'b0;
      end else begin
        if (pv && !phs) begin
          chk("out_hold_valid", 150'(ifc.out_valid), 150'(1));
          chk("out_hold_data",  150'(ifc.out_data),  150'(pd));
        end
        if (ifc.out_valid && ifc.out_ready) begin
          if (exp_q.size() == 0) timeout("unexpected_out", int'(ifc.out_data), -1);
          else begin
            e = exp_q.pop_front();
            chk("out_data", 150'(ifc.out_data), 150'(e));
          end
        end
        pv  = ifc.out_valid;
        pd  = ifc.out_data;
        phs = ifc.out_valid & ifc.out_ready;
      end
    end
  end

  task automatic load_kernel(input bit gaps, input bit px_with);
    int i = 0;
    int g = 0;
    @(negedge clk);
    ifc.k_load_start = 1'b1;
    ifc.px_valid     = px_with;
    ifc.px_data      = 6'h2a;
    #1 chk("start_px_ready", 150'(ifc.px_ready), 150'(0));
    @(posedge clk); #1;
    ifc.k_load_start = 1'b0;
    ifc.px_valid     = 1'b0;
    while (i < TAPS && g < 200) begin
      @(negedge clk); g++;
      ifc.k_wr_en   = gaps ? 1'($urandom % 2) : 1'b1;
      ifc.k_wr_data = new_ker[i];
      #1;
      if (i == 12) begin
        chk("mid_load_k_loaded", 150'(ifc.k_loaded), 150'(0));
        chk("mid_load_busy",     150'(ifc.busy),     150'(1));
        chk("mid_load_px_ready", 150'(ifc.px_ready), 150'(0));
      end
      @(posedge clk);
      if (ifc.k_wr_en) i++;
      #1 ifc.k_wr_en = 1'b0;
    end
    if (i < TAPS) timeout("kload_timeout", i, TAPS);
    ker_m = new_ker;
    @(negedge clk); #1;
    chk("k_loaded",    150'(ifc.k_loaded),    150'(1));
    chk("conv_kernel", 150'(ifc.conv_kernel), 150'(ker_m));
    chk("busy_after_load", 150'(ifc.busy),    150'(0));
  endtask

  // mode 0: back-to-back, 1: toggling valid, 2: random gaps
  task automatic send_window(input int mode, input int n);
    int i = 0;
    int g = 0;
    logic r;
    while (i < n && g < 500) begin
      @(negedge clk); g++;
      ifc.px_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(g % 2) : 1'($urandom % 2);
      ifc.px_data  = pix_m[i];
      #1 r = ifc.px_ready;
      @(posedge clk);
      if (ifc.px_valid && r) i++;
    end
    #1 ifc.px_valid = 1'b0;
    if (i < n) timeout("px_timeout", i, n);
    else if (n == TAPS) begin
      chk("conv_in_data", 150'(ifc.conv_in_data), 150'(pix_m));
      exp_q.push_back(dot(ker_m, pix_m));
    end
  endtask

  task automatic drain(input bit rnd);
    bit done = 1'b0;
    int g = 0;
    logic v;
    while (!done && g < 300) begin
      @(negedge clk); g++;
      ifc.out_ready = rnd ? 1'($urandom % 2) : 1'b1;
      #1 v = ifc.out_valid;
      @(posedge clk);
      if (v && ifc.out_ready) done = 1'b1;
    end
    #1 ifc.out_ready = 1'b0;
    if (!done) timeout("drain_timeout", g, 300);
  endtask

  initial begin
    rst = 1'b1;
    ifc.k_load_start = 1'b0; ifc.k_wr_en = 1'b0; ifc.k_wr_data = '0;
    ifc.px_valid = 1'b0; ifc.px_data = '0; ifc.out_ready = 1'b0;
    ker_m = '0; pix_m = '0; new_ker = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_k_loaded",  150'(ifc.k_loaded),     150'(0));
    chk("rst_busy",      150'(ifc.busy),         150'(0));
    chk("rst_out_valid", 150'(ifc.out_valid),    150'(0));
    chk("rst_out_data",  150'(ifc.out_data),     150'(0));
    chk("rst_kernel",    150'(ifc.conv_kernel),  150'(0));

    // Pixels offered with no kernel resident must be refused.
    repeat (5) begin
      @(negedge clk);
      ifc.px_valid = 1'b1; ifc.px_data = 6'd7;
      #1;
      chk("nokern_px_ready", 150'(ifc.px_ready), 150'(0));
      chk("nokern_busy",     150'(ifc.busy),     150'(0));
    end
    @(negedge clk); ifc.px_valid = 1'b0; #1;
    chk("nokern_pixels", 150'(ifc.conv_in_data), 150'(0));

    // Kernel of all ones, then a stray 26th write in IDLE.
    for (int i = 0; i < TAPS; i++) new_ker[i] = 6'd1;
    load_kernel(1'b0, 1'b0);
    @(negedge clk); ifc.k_wr_en = 1'b1; ifc.k_wr_data = 6'd5;
    @(posedge clk); #1 ifc.k_wr_en = 1'b0;
    @(negedge clk); #1;
    chk("stray_wr_kernel", 150'(ifc.conv_kernel), 150'(ker_m));
    chk("stray_wr_busy",   150'(ifc.busy),        150'(0));

    // Window of 2s: latency, then backpressure.
    for (int i = 0; i < TAPS; i++) pix_m[i] = 6'd2;
    send_window(0, TAPS);
    @(negedge clk); #1;
    chk("lat_t1_valid", 150'(ifc.out_valid), 150'(0));
    chk("lat_t1_busy",  150'(ifc.busy),      150'(1));
    @(negedge clk); #1 chk("lat_t2_valid", 150'(ifc.out_valid), 150'(0));
    @(negedge clk); #1;
    chk("lat_t3_valid", 150'(ifc.out_valid), 150'(1));
    chk("first_out",    150'(ifc.out_data),  150'(50));
    repeat (10) begin
      @(negedge clk); #1;
      chk("bp_valid",    150'(ifc.out_valid), 150'(1));
      chk("bp_px_ready", 150'(ifc.px_ready),  150'(0));
    end
    @(negedge clk); ifc.out_ready = 1'b1;
    @(negedge clk); ifc.out_ready = 1'b0; #1;
    chk("ack_valid",    150'(ifc.out_valid), 150'(0));
    chk("ack_busy",     150'(ifc.busy),      150'(0));
    chk("ack_px_ready", 150'(ifc.px_ready),  150'(1));

    // Full-scale operands with a toggling stream.
    for (int i = 0; i < TAPS; i++) new_ker[i] = 6'd63;
    load_kernel(1'b1, 1'b0);
    for (int i = 0; i < TAPS; i++) pix_m[i] = 6'd63;
    send_window(1, TAPS);
    drain(1'b0);

    // Random windows with occasional kernel reloads and random backpressure.
    repeat (6) begin
      if ($urandom % 3 == 0) begin
        for (int i = 0; i < TAPS; i++) new_ker[i] = 6'($urandom_range(0, 63));
        load_kernel(1'b1, 1'b1);
      end
      for (int i = 0; i < TAPS; i++) pix_m[i] = 6'($urandom_range(0, 63));
      send_window(2, TAPS);
      drain(1'b1);
    end

    // Reset in the middle of a window.
    for (int i = 0; i < TAPS; i++) pix_m[i] = 6'($urandom_range(1, 63));
    send_window(2, 13);
    @(negedge clk); rst = 1'b1; #1;
    chk("arst_k_loaded", 150'(ifc.k_loaded),     150'(0));
    chk("arst_busy",     150'(ifc.busy),         150'(0));
    chk("arst_pixels",   150'(ifc.conv_in_data), 150'(0));
    chk("arst_kernel",   150'(ifc.conv_kernel),  150'(0));
    chk("arst_out",      150'({ifc.out_valid, ifc.out_data}), 150'(0));
    ker_m = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk); ifc.px_valid = 1'b1; #1;
      chk("post_rst_px_ready", 150'(ifc.px_ready), 150'(0));
    end
    @(negedge clk); ifc.px_valid = 1'b0;
    for (int i = 0; i < TAPS; i++) new_ker[i] = 6'($urandom_range(0, 63));
    load_kernel(1'b0, 1'b0);
    for (int i = 0; i < TAPS; i++) pix_m[i] = 6'($urandom_range(0, 63));
    send_window(0, TAPS);
    drain(1'b0);

    @(negedge clk); #3;
    chk("queue_empty", 150'(exp_q.size()), 150'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
